// File: rtl/octave_decimator.sv
// Halves a pixel stream in both dimensions (drop or 2x2 rounded average); forwards every second blanking sample.
// Latency: 1 cycle from qualifying input sample to validout.
// Backpressure: none; accepts one sample per cycle, validin low freezes all state.
//
// Ports:
//   clock, reset            sole clock (posedge), synchronous active-high reset
//   din, validin, blanking_in   input pixel stream at WIDTH columns (WIDTH must be even)
//   dout, validout, blanking_out decimated stream at WIDTH/2 columns, half the rows
//   sync_error              sticky flag: blanking sample arrived mid-line
module octave_decimator #(
  parameter int WIDTH   = 420,
  parameter int AVERAGE = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       validin,
  input  logic       blanking_in,
  output logic [7:0] dout,
  output logic       validout,
  output logic       blanking_out,
  output logic       sync_error
);

  localparam int CW = ($clog2(WIDTH) < 2) ? 2 : $clog2(WIDTH);
  localparam int AW = CW - 1;
  localparam int HW = WIDTH / 2;
  localparam bit AVG = (AVERAGE != 0);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);

  logic [CW-1:0] col_q, col_d;
  logic          row_q, row_d;          // row parity, 0 = even
  logic          blank_phase_q, blank_phase_d;
  logic [7:0]    pair_q, pair_d;
  logic [7:0]    dout_q, dout_d;
  logic          validout_q, validout_d;
  logic          blanking_out_q, blanking_out_d;
  logic          sync_error_q, sync_error_d;

  // Horizontal pair sums of the last even row; always written before read.
  logic [8:0]    line_buf [HW];
  logic [AW-1:0] buf_addr;
  logic          buf_we;
  logic [8:0]    hsum;
  logic [9:0]    total;
  logic [7:0]    avg_pix;

  logic pix_smp;
  logic blk_smp;

  assign pix_smp  = validin & ~blanking_in;
  assign blk_smp  = validin & blanking_in;
  assign buf_addr = col_q[CW-1:1];
  assign hsum     = {1'b0, pair_q} + {1'b0, din};
  // Asynchronous buffer read so the upper pair is ready alongside the second pixel.
  assign total    = {1'b0, line_buf[buf_addr]} + {2'b00, pair_q} + {2'b00, din};
  assign avg_pix  = 8'((total + 10'd2) >> 2);

  always_comb begin
    col_d          = col_q;
    row_d          = row_q;
    blank_phase_d  = blank_phase_q;
    pair_d         = pair_q;
    dout_d         = dout_q;
    validout_d     = 1'b0;
    blanking_out_d = blanking_out_q;
    sync_error_d   = sync_error_q;
    buf_we         = 1'b0;

    if (blk_smp) begin
      // Frame boundary: realign to row 0, col 0.
      col_d         = '0;
      row_d         = 1'b0;
      blank_phase_d = ~blank_phase_q;
      if (col_q != '0) begin
        sync_error_d = 1'b1;
      end
      if (!blank_phase_q) begin
        validout_d     = 1'b1;
        blanking_out_d = 1'b1;
        dout_d         = 8'd0;
      end
    end else if (pix_smp) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = ~row_q;
      end else begin
        col_d = col_q + COL_ONE;
      end

      if (!AVG) begin
        if (!row_q && !col_q[0]) begin
          validout_d     = 1'b1;
          blanking_out_d = 1'b0;
          dout_d         = din;
        end
      end else if (!col_q[0]) begin
        pair_d = din;
      end else if (!row_q) begin
        buf_we = 1'b1;
      end else begin
        validout_d     = 1'b1;
        blanking_out_d = 1'b0;
        dout_d         = avg_pix;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q          <= '0;
      row_q          <= 1'b0;
      blank_phase_q  <= 1'b0;
      pair_q         <= 8'd0;
      dout_q         <= 8'd0;
      validout_q     <= 1'b0;
      blanking_out_q <= 1'b1;
      sync_error_q   <= 1'b0;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      blank_phase_q  <= blank_phase_d;
      pair_q         <= pair_d;
      dout_q         <= dout_d;
      validout_q     <= validout_d;
      blanking_out_q <= blanking_out_d;
      sync_error_q   <= sync_error_d;
    end
  end

  always_ff @(posedge clock) begin
    if (buf_we && !reset) begin
      line_buf[buf_addr] <= hsum;
    end
  end

  assign dout         = dout_q;
  assign validout     = validout_q;
  assign blanking_out = blanking_out_q;
  assign sync_error   = sync_error_q;

endmodule

// File: tb/tb_octave_decimator.sv
// Drives one stimulus stream into a drop-mode and an average-mode decimator (WIDTH=8)
// and compares every output cycle against a frame-array reference model.
// Directed frames add fixed expected value tables on top of the model.
module tb_octave_decimator;

  localparam int W = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'd0;
  logic       validin = 1'b0;
  logic       blanking_in = 1'b0;

  logic [7:0] drp_dout, avg_dout;
  logic       drp_vld, avg_vld, drp_bo, avg_bo, drp_se, avg_se;

  octave_decimator #(.WIDTH(W), .AVERAGE(0)) u_drop (
    .clock(clock), .reset(reset), .din(din), .validin(validin), .blanking_in(blanking_in),
    .dout(drp_dout), .validout(drp_vld), .blanking_out(drp_bo), .sync_error(drp_se));

  octave_decimator #(.WIDTH(W), .AVERAGE(1)) u_avg (
    .clock(clock), .reset(reset), .din(din), .validin(validin), .blanking_in(blanking_in),
    .dout(avg_dout), .validout(avg_vld), .blanking_out(avg_bo), .sync_error(avg_se));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: pixels of the current frame are kept in order; position is
  // derived from the pixel count, and 2x2 blocks are read straight from the array.
  logic [7:0] m_frame[$];
  int         m_nblank = 0;
  bit         m_sync = 0;
  bit         m_vld_d, m_vld_a;
  logic [7:0] m_dout_d = 8'd0, m_dout_a = 8'd0;
  bit         m_bo_d = 1, m_bo_a = 1;

  logic [7:0] got_drop[$];
  logic [7:0] got_avg[$];
  int         blank_outs = 0;

  task automatic compare_outputs();
    check("drop_validout", drp_vld, m_vld_d);
    check("drop_dout", drp_dout, m_dout_d);
    check("drop_blanking_out", drp_bo, m_bo_d);
    check("drop_sync_error", drp_se, m_sync);
    check("avg_validout", avg_vld, m_vld_a);
    check("avg_dout", avg_dout, m_dout_a);
    check("avg_blanking_out", avg_bo, m_bo_a);
    check("avg_sync_error", avg_se, m_sync);
    if (drp_vld && !drp_bo) got_drop.push_back(drp_dout);
    if (avg_vld && !avg_bo) got_avg.push_back(avg_dout);
    if (drp_vld && drp_bo) blank_outs++;
  endtask

  task automatic cycle(input bit v, input bit b, input logic [7:0] d);
    int n, col, row, sum;
    @(negedge clock);
    reset = 1'b0; validin = v; blanking_in = b; din = d;
    m_vld_d = 0; m_vld_a = 0;
    if (v && b) begin
      if (m_frame.size() % W != 0) m_sync = 1;
      if (m_nblank % 2 == 0) begin
        m_vld_d = 1; m_vld_a = 1;
        m_dout_d = 8'd0; m_dout_a = 8'd0;
        m_bo_d = 1; m_bo_a = 1;
      end
      m_nblank++;
      m_frame.delete();
    end else if (v) begin
      n = m_frame.size();
      col = n % W;
      row = n / W;
      if (row % 2 == 0 && col % 2 == 0) begin
        m_vld_d = 1; m_bo_d = 0; m_dout_d = d;
      end
      if (row % 2 == 1 && col % 2 == 1) begin
        sum = int'(m_frame[(row-1)*W + col-1]) + int'(m_frame[(row-1)*W + col])
            + int'(m_frame[n-1]) + int'(d);
        m_vld_a = 1; m_bo_a = 0; m_dout_a = 8'((sum + 2) / 4);
      end
      m_frame.push_back(d);
    end
    @(posedge clock);
    #1;
    compare_outputs();
  endtask

  task automatic cycle_rst(input bit v, input bit b, input logic [7:0] d);
    @(negedge clock);
    reset = 1'b1; validin = v; blanking_in = b; din = d;
    m_frame.delete();
    m_nblank = 0; m_sync = 0;
    m_vld_d = 0; m_vld_a = 0;
    m_dout_d = 8'd0; m_dout_a = 8'd0;
    m_bo_d = 1; m_bo_a = 1;
    @(posedge clock);
    #1;
    compare_outputs();
  endtask

  logic [7:0] stim[$];

  task automatic run_stim(input bit gaps);
    foreach (stim[i]) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1)
          cycle(1'b0, 1'(($urandom_range(0, 1))), 8'($urandom));
      end
      cycle(1'b1, 1'b0, stim[i]);
    end
  endtask

  task automatic make_frame_a(input int rows);
    stim.delete();
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < W; c++)
        stim.push_back(8'(16*r + c));
  endtask

  logic [7:0] ref_drop[$];
  logic [7:0] ref_avg[$];
  logic [7:0] tbl_drop[8] = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd32, 8'd34, 8'd36, 8'd38};
  logic [7:0] tbl_avg[8]  = '{8'd9, 8'd11, 8'd13, 8'd15, 8'd41, 8'd43, 8'd45, 8'd47};

  initial begin
    // Reset values
    cycle_rst(1'b1, 1'b0, 8'h55);
    cycle_rst(1'b0, 1'b0, 8'h00);

    // Ramp frame, continuous valid
    got_drop.delete(); got_avg.delete();
    make_frame_a(4);
    run_stim(1'b0);
    check("ramp_drop_count", got_drop.size(), 8);
    check("ramp_avg_count", got_avg.size(), 8);
    for (int i = 0; i < 8 && i < got_drop.size(); i++) check("ramp_drop_val", got_drop[i], tbl_drop[i]);
    for (int i = 0; i < 8 && i < got_avg.size(); i++) check("ramp_avg_val", got_avg[i], tbl_avg[i]);

    // Six blanking samples: 1st, 3rd, 5th forwarded
    blank_outs = 0;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 8'($urandom));
    check("blank_fwd_count", blank_outs, 3);
    check("blank_sync_clear", drp_se, 1'b0);

    // Saturated frame
    got_avg.delete();
    stim.delete();
    for (int i = 0; i < 4*W; i++) stim.push_back(8'd255);
    run_stim(1'b0);
    check("sat_avg_count", got_avg.size(), 8);
    if (got_avg.size() > 0) check("sat_avg_val", got_avg[got_avg.size()-1], 255);

    // Rounding block 1,1 / 1,2 -> 1
    cycle(1'b1, 1'b1, 8'd0);
    got_avg.delete();
    stim.delete();
    for (int i = 0; i < W; i++) stim.push_back(8'd1);
    for (int i = 0; i < W; i++) stim.push_back((i % 2 == 1) ? 8'd2 : 8'd1);
    run_stim(1'b0);
    if (got_avg.size() > 0) check("round_avg_val", got_avg[0], 1);
    else check("round_avg_count", got_avg.size(), 4);

    // Blanking at col 3 -> sticky sync_error, next pixel restarts at row 0 col 0
    cycle(1'b1, 1'b1, 8'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'($urandom));
    cycle(1'b1, 1'b1, 8'd0);
    check("sync_rise", avg_se, 1'b1);
    got_drop.delete();
    cycle(1'b1, 1'b0, 8'd77);
    check("resync_drop_count", got_drop.size(), 1);
    if (got_drop.size() > 0) check("resync_drop_val", got_drop[0], 77);
    for (int i = 0; i < 5; i++) cycle(1'(($urandom_range(0, 1))), 1'b0, 8'($urandom));
    check("sync_sticky", drp_se, 1'b1);
    cycle_rst(1'b1, 1'b1, 8'd0);

    // Random frame: continuous vs gapped valid must give identical outputs
    stim.delete();
    for (int i = 0; i < 4*W; i++) stim.push_back(8'($urandom));
    got_drop.delete(); got_avg.delete();
    run_stim(1'b0);
    ref_drop = got_drop; ref_avg = got_avg;
    cycle(1'b1, 1'b1, 8'd0);
    got_drop.delete(); got_avg.delete();
    run_stim(1'b1);
    check("gap_drop_count", got_drop.size(), 8);
    check("gap_avg_count", got_avg.size(), 8);
    for (int i = 0; i < ref_drop.size() && i < got_drop.size(); i++) check("gap_drop_val", got_drop[i], ref_drop[i]);
    for (int i = 0; i < ref_avg.size() && i < got_avg.size(); i++) check("gap_avg_val", got_avg[i], ref_avg[i]);

    // Reset mid odd row, then the ramp frame again
    cycle(1'b1, 1'b1, 8'd0);
    for (int i = 0; i < W + 4; i++) cycle(1'b1, 1'b0, 8'($urandom));
    cycle_rst(1'b1, 1'b0, 8'($urandom));
    cycle_rst(1'b1, 1'b0, 8'($urandom));
    got_drop.delete(); got_avg.delete();
    make_frame_a(2);
    run_stim(1'b0);
    check("post_rst_avg_count", got_avg.size(), 4);
    for (int i = 0; i < 4 && i < got_avg.size(); i++) check("post_rst_avg_val", got_avg[i], tbl_avg[i]);
    for (int i = 0; i < 4 && i < got_drop.size(); i++) check("post_rst_drop_val", got_drop[i], tbl_drop[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
